// File: rtl/arith_pkg.sv
// Shared encodings for the sequential arithmetic unit: operation codes and
// the control FSM states.
package arith_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_MUL = 2'b10,
      OP_DIV = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      DONE = 2'b10
   } state_t;

endpackage

// File: rtl/seq_muldiv_core.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one bit per step.
// The hi/lo register pair holds {acc, multiplier} or {remainder, quotient}.
module seq_muldiv_core
   import arith_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic                 step,
   input  logic                 mode,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 done,
   output logic [2*WIDTH-1:0]   result
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   logic [WIDTH-1:0] hi, lo, opd;
   logic [WIDTH-1:0] hi_n, lo_n;
   logic [WIDTH:0]   trial, sum;
   logic             is_div;
   logic [CW-1:0]    cnt;

   always_comb begin
      hi_n  = hi;
      lo_n  = lo;
      trial = '0;
      sum   = '0;
      if (is_div) begin
         // Shift the next dividend bit into the partial remainder and try to subtract.
         trial = {hi, lo[WIDTH-1]};
         if (trial >= {1'b0, opd}) begin
            hi_n = trial[WIDTH-1:0] - opd;
            lo_n = {lo[WIDTH-2:0], 1'b1};
         end else begin
            hi_n = trial[WIDTH-1:0];
            lo_n = {lo[WIDTH-2:0], 1'b0};
         end
      end else begin
         sum  = {1'b0, hi} + (lo[0] ? {1'b0, opd} : '0);
         hi_n = sum[WIDTH:1];
         lo_n = {sum[0], lo[WIDTH-1:1]};
      end
   end

   // Result reflects the step being taken this cycle so the top can capture it
   // on the same edge that ends the final step.
   assign done   = step && (cnt == CW'(WIDTH - 1));
   assign result = {hi_n, lo_n};

   always_ff @(posedge clk) begin
      if (rst) begin
         hi     <= '0;
         lo     <= '0;
         opd    <= '0;
         is_div <= 1'b0;
         cnt    <= '0;
      end else if (load) begin
         hi     <= '0;
         lo     <= mode ? a : b;
         opd    <= mode ? b : a;
         is_div <= mode;
         cnt    <= '0;
      end else if (step) begin
         hi  <= hi_n;
         lo  <= lo_n;
         cnt <= done ? '0 : cnt + CW'(1);
      end
   end

endmodule

// File: rtl/seq_arith_unit.sv
// Registered add/sub/mul/div unit with a valid/ready request side and one
// held result channel per operation.
module seq_arith_unit
   import arith_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic [1:0]           op,
   output logic [2*WIDTH-1:0]   y_add,
   output logic [2*WIDTH-1:0]   y_sub,
   output logic [2*WIDTH-1:0]   y_mul,
   output logic [2*WIDTH-1:0]   y_div,
   output logic                 out_valid,
   output logic [1:0]           out_op,
   output logic                 div_by_zero,
   output logic                 busy,
   output logic [1:0]           dbg_state
);

   localparam int RW = 2 * WIDTH;

   // Handshake: a request transfers on a rising edge where in_valid and in_ready
   // are both high; in_valid must be held until then, results have no backpressure.
   state_t           state, state_n;
   logic [WIDTH-1:0] a_q, b_q;
   op_t              op_q;
   logic             dz_q, accept, finish, long_op, core_step, core_done;
   logic [RW-1:0]    core_result, result;

   assign in_ready  = (state == IDLE) && !en_n;
   assign accept    = in_valid && in_ready;
   assign long_op   = (op_q == OP_MUL) || ((op_q == OP_DIV) && !dz_q);
   assign core_step = (state == CALC) && !en_n && long_op;
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign dbg_state = state;

   seq_muldiv_core #(.WIDTH(WIDTH)) u_core (
      .clk    (clk),
      .rst    (rst),
      .load   (accept),
      .step   (core_step),
      .mode   (op == OP_DIV),
      .a      (a),
      .b      (b),
      .done   (core_done),
      .result (core_result)
   );

   always_comb begin
      state_n = state;
      finish  = 1'b0;
      case (state)
         IDLE: if (accept) state_n = CALC;
         CALC: begin
            // A stalled cycle neither steps the core nor completes a short op.
            if (!en_n && (!long_op || core_done)) begin
               state_n = DONE;
               finish  = 1'b1;
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      result = core_result;
      case (op_q)
         OP_ADD:  result = RW'(a_q) + RW'(b_q);
         OP_SUB:  result = RW'(a_q) - RW'(b_q);
         OP_DIV:  if (dz_q) result = {a_q, {WIDTH{1'b1}}};
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= OP_ADD;
         dz_q        <= 1'b0;
         y_add       <= '0;
         y_sub       <= '0;
         y_mul       <= '0;
         y_div       <= '0;
         out_op      <= 2'b00;
         div_by_zero <= 1'b0;
      end else begin
         state <= state_n;
         if (accept) begin
            a_q  <= a;
            b_q  <= b;
            op_q <= op_t'(op);
            dz_q <= (op == OP_DIV) && (b == '0);
         end
         if (finish) begin
            case (op_q)
               OP_ADD:  y_add <= result;
               OP_SUB:  y_sub <= result;
               OP_MUL:  y_mul <= result;
               default: y_div <= result;
            endcase
            out_op      <= op_q;
            div_by_zero <= dz_q;
         end
      end
   end

endmodule

// File: tb/tb_seq_arith_unit.sv
// Directed bench for seq_arith_unit (WIDTH=8) with a cycle-level reference
// model, a per-cycle compare process and hand-computed literal checks.
module tb_seq_arith_unit;

   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           en_n = 1'b0;
   logic           in_valid = 1'b0;
   logic [W-1:0]   a = '0;
   logic [W-1:0]   b = '0;
   logic [1:0]     op = 2'b00;
   logic           in_ready, out_valid, div_by_zero, busy;
   logic [2*W-1:0] y_add, y_sub, y_mul, y_div;
   logic [1:0]     out_op, dbg_state;

   always #5 clk = ~clk;

   seq_arith_unit #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .en_n        (en_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .a           (a),
      .b           (b),
      .op          (op),
      .y_add       (y_add),
      .y_sub       (y_sub),
      .y_mul       (y_mul),
      .y_div       (y_div),
      .out_valid   (out_valid),
      .out_op      (out_op),
      .div_by_zero (div_by_zero),
      .busy        (busy),
      .dbg_state   (dbg_state)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   bit chk_on   = 1'b0;
   int vcyc[4]  = '{-1, -1, -1, -1};

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   logic [2*W-1:0] exp_ch[4];
   logic [2*W-1:0] exp_q[$];
   logic [1:0]     exp_op, m_op;
   logic           exp_dz, m_dz;
   logic [2*W-1:0] m_res;
   bit             m_pending, m_pulse;
   int             m_left;

   function automatic logic [2*W-1:0] model_res(input logic [W-1:0] x, input logic [W-1:0] y,
                                                input logic [1:0] o, output logic dz);
      int unsigned ux = x;
      int unsigned uy = y;
      int unsigned r;
      dz = 1'b0;
      case (o)
         2'd0: r = ux + uy;
         2'd1: r = ux - uy;
         2'd2: r = ux * uy;
         default: begin
            if (uy == 0) begin
               dz = 1'b1;
               r  = (ux << W) | ((1 << W) - 1);
            end else begin
               r = ((ux % uy) << W) | (ux / uy);
            end
         end
      endcase
      return r[2*W-1:0];
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) exp_ch[i] = '0;
         exp_op    = 2'b00;
         exp_dz    = 1'b0;
         m_pending = 1'b0;
         m_pulse   = 1'b0;
         m_left    = 0;
         exp_q.delete();
      end else if (m_pulse) begin
         m_pulse = 1'b0;
      end else if (m_pending) begin
         if (!en_n) begin
            m_left--;
            if (m_left == 0) begin
               m_pending  = 1'b0;
               m_pulse    = 1'b1;
               exp_ch[m_op] = m_res;
               exp_op     = m_op;
               exp_dz     = m_dz;
            end
         end
      end else if (in_valid && !en_n) begin
         m_op      = op;
         m_res     = model_res(a, b, op, m_dz);
         m_left    = (op == 2'd2 || (op == 2'd3 && b != 0)) ? W : 1;
         m_pending = 1'b1;
         exp_q.push_back(m_res);
      end
   end

   function automatic bit exp_ready();
      return !m_pending && !m_pulse && !en_n;
   endfunction

   function automatic logic [2*W-1:0] chan(input logic [1:0] o);
      case (o)
         2'd0: return y_add;
         2'd1: return y_sub;
         2'd2: return y_mul;
         default: return y_div;
      endcase
   endfunction

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (out_valid === 1'b1) vcyc[out_op] = cyc;
   end

   always @(negedge clk) begin
      #2;
      if (chk_on) begin
         check("y_add", y_add, exp_ch[0]);
         check("y_sub", y_sub, exp_ch[1]);
         check("y_mul", y_mul, exp_ch[2]);
         check("y_div", y_div, exp_ch[3]);
         check("out_valid", out_valid, m_pulse);
         check("out_op", out_op, exp_op);
         check("div_by_zero", div_by_zero, exp_dz);
         check("busy", busy, m_pending || m_pulse);
         check("in_ready", in_ready, exp_ready());
         if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("unexpected_result", 32'd1, 32'd0);
            end else begin
               logic [2*W-1:0] e;
               e = exp_q.pop_front();
               check("result_channel", chan(out_op), e);
            end
         end
      end
   end

   // ---------------- drivers ----------------
   task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [1:0] iop,
                        output int t);
      @(negedge clk);
      a = ia; b = ib; op = iop; in_valid = 1'b1;
      for (int k = 0; k < 60; k++) begin
         if (exp_ready()) break;
         @(negedge clk);
      end
      if (!exp_ready()) check("issue_timeout", 32'd1, 32'd0);
      t = cyc;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_op(input int o, input int t, input int lat, input string name);
      for (int k = 0; k < 40; k++) begin
         if (vcyc[o] > t) break;
         @(negedge clk);
         #1;
      end
      check(name, vcyc[o] - t, lat);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int t, t2, vm;
      repeat (3) @(negedge clk);
      chk_on = 1'b1;
      rst = 1'b0;
      #1;
      check("rst_y_add", y_add, 16'd0);
      check("rst_y_div", y_div, 16'd0);
      check("rst_busy", busy, 1'b0);
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_out_valid", out_valid, 1'b0);

      // add 200+100
      issue(8'd200, 8'd100, 2'd0, t);
      wait_op(0, t, 2, "lat_add");
      check("add_300", y_add, 16'd300);
      check("add_others_mul", y_mul, 16'd0);
      check("add_others_sub", y_sub, 16'd0);

      // sub 5-7 then mul 255*255
      issue(8'd5, 8'd7, 2'd1, t);
      wait_op(1, t, 2, "lat_sub");
      check("sub_fffe", y_sub, 16'hFFFE);
      issue(8'd255, 8'd255, 2'd2, t);
      wait_op(2, t, 9, "lat_mul");
      check("mul_fe01", y_mul, 16'hFE01);
      check("sub_held", y_sub, 16'hFFFE);

      // div 200/7 then div by zero
      issue(8'd200, 8'd7, 2'd3, t);
      wait_op(3, t, 9, "lat_div");
      check("div_041c", y_div, 16'h041C);
      check("div_dz0", div_by_zero, 1'b0);
      issue(8'd9, 8'd0, 2'd3, t);
      wait_op(3, t, 2, "lat_divz");
      check("divz_09ff", y_div, 16'h09FF);
      check("divz_flag", div_by_zero, 1'b1);

      // mul 3*4 with three stalled cycles, add request held meanwhile
      issue(8'd3, 8'd4, 2'd2, t);
      fork
         issue(8'd1, 8'd2, 2'd0, t2);
         begin
            @(negedge clk);
            @(negedge clk);
            en_n = 1'b1;
            repeat (3) @(negedge clk);
            en_n = 1'b0;
         end
      join
      wait_op(2, t, 12, "lat_mul_stall");
      check("mul_12", y_mul, 16'd12);
      check("held_accept_gap", t2 - t, 13);
      wait_op(0, t2, 2, "lat_add_held");
      check("add_3", y_add, 16'd3);
      check("dz_cleared", div_by_zero, 1'b0);

      // reset mid-multiply
      issue(8'd15, 8'd15, 2'd2, t);
      while (cyc < t + 4) @(negedge clk);
      vm = vcyc[2];
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("abort_y_mul", y_mul, 16'd0);
      check("abort_y_add", y_add, 16'd0);
      check("abort_busy", busy, 1'b0);
      repeat (12) @(negedge clk);
      check("abort_no_pulse", vcyc[2], vm);
      issue(8'd10, 8'd20, 2'd0, t);
      wait_op(0, t, 2, "lat_add_after_rst");
      check("add_30", y_add, 16'd30);

      // en_n blocks acceptance in IDLE
      @(negedge clk);
      en_n = 1'b1; a = 8'd50; b = 8'd60; op = 2'd0; in_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         #1;
         check("en_n_ready_low", in_ready, 1'b0);
         check("en_n_idle", busy, 1'b0);
      end
      en_n = 1'b0;
      #1;
      check("en_n_ready_high", in_ready, 1'b1);
      t = cyc;
      @(posedge clk);
      #1 in_valid = 1'b0;
      wait_op(0, t, 2, "lat_add_en");
      check("add_110", y_add, 16'd110);

      repeat (3) @(negedge clk);
      check("queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_arith_unit.md
# seq_arith_unit

Parametrised, registered successor to the team's combinational 8-bit arithmetic unit and 4-way result demux. It accepts one operation at a time (add, sub, mul, div) on WIDTH-bit unsigned operands through a valid/ready handshake. Add and sub complete in one compute cycle. Mul and div run iteratively (shift-add / restoring) over WIDTH cycles. Each result lands in a per-operation output channel that holds its value until the next result of the same operation overwrites it.

## Interface
Parameters:
- WIDTH, default 8: operand width; results are 2*WIDTH; must be >= 2.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- en_n  in  1  active-low enable; gates acceptance and stalls computation
- in_valid  in  1  operation request
- in_ready  out  1  = (state==IDLE) & !en_n
- a, b  in  WIDTH  unsigned operands
- op  in  2  00 add, 01 sub, 10 mul, 11 div
- y_add, y_sub, y_mul, y_div  out  2*WIDTH  per-operation result channels
- out_valid  out  1  one-cycle pulse, result channel just updated
- out_op  out  2  operation of the current/last result
- div_by_zero  out  1  sticky per result; set with a div-by-zero result, cleared by the next out_valid
- busy  out  1  state != IDLE

## Operation
- Accept when in_valid & in_ready at a rising edge (cycle T). Latch a, b, op. Go to CALC.
- FSM: IDLE -> CALC -> DONE -> IDLE.
  - CALC lasts N active cycles: N=1 for add, sub and div-by-zero; N=WIDTH for mul and div.
  - DONE lasts exactly one cycle. out_valid=1 in DONE.
  - Only the channel selected by the latched op, plus out_op and div_by_zero, update on entering DONE.
- Stall: in CALC, en_n=1 freezes the counter and the datapath. DONE and IDLE are unaffected by en_n.
- Arithmetic (all modulo 2^(2*WIDTH)):
  - add: zero-extended a+b, carry lands in bit WIDTH.
  - sub: zero-extended a minus zero-extended b, giving a two's-complement 2*WIDTH result (negative sign-extends).
  - mul: unsigned product, shift-add, one partial-product step per CALC cycle.
  - div: restoring division, one quotient bit per cycle. Result = {remainder, quotient}.
- Div by zero (b==0, op=11): detected at accept, N=1. Result = {a, all-ones}, div_by_zero=1.
- in_valid while busy is ignored (in_ready=0); the requester holds it.
- Reset values: all channels 0, out_valid 0, out_op 00, div_by_zero 0, busy 0, state IDLE, in_ready = !en_n.
- rst mid-operation: abort immediately. No out_valid is issued and all channels return to 0.

## Timing
- Result visible and out_valid high in cycle T+N+1, plus any stall cycles. For WIDTH=8: add/sub T+2, mul/div T+9.
- Back-to-back issue: in_ready returns in the cycle after DONE, so the minimum add-to-add spacing is 3 cycles.
- Channel outputs and out_op are registered and stable from DONE until the next update or reset.
- No output backpressure; out_valid is a pulse.

## Structure
- Shared package arith_pkg:
  - op encodings OP_ADD/OP_SUB/OP_MUL/OP_DIV
  - FSM state encoding IDLE/CALC/DONE
- Sub-module seq_muldiv_core(WIDTH):
  - holds the accumulator/remainder, shift register and step counter
  - inputs: load, step enable, mode
  - output: done
- Top level holds the FSM, handshake, add/sub datapath and channel registers.

## Test plan
(WIDTH=8)
1. Reset, then add a=200, b=100 accepted at T -> y_add=16'd300 with out_valid at T+2; other channels stay 0.
2. sub a=5, b=7 -> y_sub=16'hFFFE at T+2. Then mul a=255, b=255 -> y_mul=16'hFE01 at T+9. y_sub still 16'hFFFE.
3. div a=200, b=7 -> y_div=16'h041C (r=4, q=28) at T+9, div_by_zero=0. Then div a=9, b=0 -> y_div=16'h09FF, div_by_zero=1 at T+2.
4. mul 3*4 with en_n=1 for 3 cycles mid-CALC -> y_mul=16'd12, out_valid at T+12. in_valid held while busy produces no second accept until in_ready.
5. Issue mul 15*15, assert rst at T+4 -> next cycle all channels 0, busy 0, no out_valid; a new add then completes normally.
6. en_n=1 in IDLE with in_valid=1 -> in_ready=0, nothing accepted; drop en_n -> accepted that cycle.
